// File: rtl/i2s_frame_tx.sv
// i2s_frame_tx: Philips I2S transmitter with one-deep sample-pair holding
// register; bclk/lrclk derived from clk, silence plus underrun when starved.
module i2s_frame_tx #(
  parameter int WIDTH     = 24,
  parameter int SLOT_BITS = 32,
  parameter int BCLK_DIV  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sample_left,
  input  logic [WIDTH-1:0] sample_right,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic             bclk,
  output logic             lrclk,
  output logic             sdata,
  output logic             underrun
);

  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int CW = $clog2(2 * SLOT_BITS);

  localparam logic [DW-1:0] DIV_MAX = DW'(BCLK_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(2 * SLOT_BITS - 1);
  localparam logic [CW-1:0] SLOT    = CW'(SLOT_BITS);
  localparam logic [CW-1:0] WLEN    = CW'(WIDTH);

  logic [DW-1:0]    div_cnt;
  logic [CW-1:0]    bit_cnt;
  logic [CW-1:0]    bit_nxt;
  logic [CW-1:0]    pos;
  logic             right_nxt;
  logic             data_bit;
  logic             fall;
  logic             frame_start;
  logic             shift_en;
  logic             accept;
  logic             hold_full;
  logic             hold_nxt;
  logic [WIDTH-1:0] hold_l;
  logic [WIDTH-1:0] hold_r;
  logic [WIDTH-1:0] sh_l;
  logic [WIDTH-1:0] sh_r;

  assign fall        = bclk && (div_cnt == DIV_MAX);
  assign frame_start = fall && (bit_cnt == CNT_MAX);
  assign accept      = sample_valid && sample_ready;
  assign hold_nxt    = accept || (hold_full && !frame_start);

  // Slot decode is done on the post-increment count so that sdata and
  // lrclk change together on the falling event.
  always_comb begin
    bit_nxt   = (bit_cnt == CNT_MAX) ? '0 : bit_cnt + 1'b1;
    right_nxt = (bit_nxt >= SLOT);
    pos       = right_nxt ? bit_nxt - SLOT : bit_nxt;
    data_bit  = right_nxt ? sh_r[WIDTH-1] : sh_l[WIDTH-1];
    shift_en  = fall && (pos != '0) && (pos <= WLEN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
      bit_cnt <= CNT_MAX;
      lrclk   <= 1'b1;
      sdata   <= 1'b0;
    end else begin
      if (div_cnt == DIV_MAX) begin
        div_cnt <= '0;
        bclk    <= !bclk;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (fall) begin
        bit_cnt <= bit_nxt;
        lrclk   <= right_nxt;
        sdata   <= shift_en ? data_bit : 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full    <= 1'b0;
      hold_l       <= '0;
      hold_r       <= '0;
      sh_l         <= '0;
      sh_r         <= '0;
      underrun     <= 1'b0;
      sample_ready <= 1'b0;
    end else begin
      underrun <= frame_start && !hold_full;
      // The frame load sees the pre-edge hold, so a pair accepted on the
      // same edge waits for the next frame.
      if (frame_start) begin
        sh_l <= hold_full ? hold_l : '0;
        sh_r <= hold_full ? hold_r : '0;
      end else if (shift_en) begin
        if (right_nxt) sh_r <= sh_r << 1;
        else           sh_l <= sh_l << 1;
      end
      if (accept) begin
        hold_l <= sample_left;
        hold_r <= sample_right;
      end
      hold_full    <= hold_nxt;
      sample_ready <= !hold_nxt;
    end
  end

endmodule

// File: tb/tb_i2s_frame_tx.sv
// tb_i2s_frame_tx: time-indexed I2S reference model with per-cycle
// output comparison, directed scenarios and a randomized traffic phase.
module tb_i2s_frame_tx;

  localparam int W  = 24;
  localparam int SB = 32;
  localparam int BD = 4;
  localparam int HP = 2 * BD;
  localparam int FR = 2 * SB * HP;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] sample_left = '0;
  logic [W-1:0] sample_right = '0;
  logic         sample_valid = 1'b0;
  logic         sample_ready;
  logic         bclk;
  logic         lrclk;
  logic         sdata;
  logic         underrun;

  i2s_frame_tx #(.WIDTH(W), .SLOT_BITS(SB), .BCLK_DIV(BD)) dut (
    .clk(clk),
    .rst(rst),
    .sample_left(sample_left),
    .sample_right(sample_right),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .bclk(bclk),
    .lrclk(lrclk),
    .sdata(sdata),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Model: t counts clk edges since reset release; frames are the pairs
  // (or silence) the link must carry, in order.
  bit           started = 1'b0;
  int           t = 0;
  bit           hf = 1'b0;
  bit           rdy_m;
  logic [W-1:0] hl, hr;
  logic [W-1:0] fl[$];
  logic [W-1:0] fr[$];
  bit           fu[$];
  int           und_t[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", name, t, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      started = 1'b1;
      t = 0;
      hf = 1'b0;
      fl.delete();
      fr.delete();
      fu.delete();
    end else begin
      rdy_m = (t >= 1) && !hf;
      t = t + 1;
      if (t >= HP && (t - HP) % FR == 0) begin
        fl.push_back(hf ? hl : '0);
        fr.push_back(hf ? hr : '0);
        fu.push_back(!hf);
        hf = 1'b0;
      end
      if (sample_valid && rdy_m) begin
        hf = 1'b1;
        hl = sample_left;
        hr = sample_right;
      end
    end
  end

  int           f_m, bc_m, k_m, p_m;
  logic [W-1:0] w_m;
  logic         e_lr, e_sd, e_ur;

  always @(negedge clk) begin
    if (started) begin
      if (t == 0) begin
        chk("rst_bclk", bclk, 0);
        chk("rst_lrclk", lrclk, 1);
        chk("rst_sdata", sdata, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_ready", sample_ready, 0);
      end else begin
        f_m  = t / HP;
        e_lr = 1'b1;
        e_sd = 1'b0;
        e_ur = 1'b0;
        if (f_m > 0) begin
          bc_m = (f_m - 1) % (2 * SB);
          k_m  = (f_m - 1) / (2 * SB);
          p_m  = bc_m % SB;
          e_lr = (bc_m >= SB);
          w_m  = '0;
          if (k_m < fl.size()) w_m = e_lr ? fr[k_m] : fl[k_m];
          if (p_m >= 1 && p_m <= W) e_sd = w_m[W-p_m];
          if ((t - HP) % FR == 0 && k_m < fu.size()) e_ur = fu[k_m];
        end
        chk("bclk", bclk, (t / BD) % 2);
        chk("lrclk", lrclk, e_lr);
        chk("sdata", sdata, e_sd);
        chk("underrun", underrun, e_ur);
        chk("ready", sample_ready, !hf);
        if (underrun === 1'b1) und_t.push_back(t);
      end
    end
  end

  task automatic wait_t(input int target);
    int n = 0;
    if (t > target) chk("sched_late", t, target);
    while (t < target && n < 100000) begin
      @(negedge clk);
      n++;
    end
    if (t < target) chk("sched_timeout", t, target);
  endtask

  task automatic wait_acc();
    int n = 0;
    while (!hf && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!hf) chk("accept_timeout", 0, 1);
  endtask

  task automatic get_word(input int ts, input bit ch,
                          output logic [W-1:0] w);
    w = '0;
    for (int p = 1; p <= W; p++) begin
      wait_t(ts + ((ch ? SB : 0) + p) * HP + 1);
      w[W-p] = sdata;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sample_valid = 1'b0;
    repeat (3) @(negedge clk);
    und_t.delete();
    rst = 1'b0;
    chk("lit_rst_ready", sample_ready, 0);
    chk("lit_rst_lrclk", lrclk, 1);
    chk("lit_rst_bclk", bclk, 0);
    chk("lit_rst_sdata", sdata, 0);
  endtask

  logic [W-1:0] wd;

  initial begin
    // Reset timing and starvation
    do_reset();
    wait_t(3);  chk("lit_bclk3", bclk, 0);
    wait_t(4);  chk("lit_bclk4", bclk, 1);
    wait_t(8);
    chk("lit_bclk8", bclk, 0);
    chk("lit_lr8", lrclk, 0);
    chk("lit_ur8", underrun, 1);
    wait_t(9);  chk("lit_ur9", underrun, 0);
    wait_t(HP + 2 * FR + 4);
    chk("lit_ur_count", und_t.size(), 3);
    if (und_t.size() >= 3) begin
      chk("lit_ur_first", und_t[0], 8);
      chk("lit_ur_gap1", und_t[1] - und_t[0], 512);
      chk("lit_ur_gap2", und_t[2] - und_t[1], 512);
    end

    // Single pair
    do_reset();
    wait_t(1);
    sample_left = 24'hABCDEF;
    sample_right = 24'h123456;
    sample_valid = 1'b1;
    wait_acc();
    sample_valid = 1'b0;
    wait_t(8);  chk("lit_sp_ur", underrun, 0);
    get_word(8, 1'b0, wd); chk("lit_sp_left", wd, 24'hABCDEF);
    wait_t(8 + 32 * HP - 1); chk("lit_sp_lr_lo", lrclk, 0);
    wait_t(8 + 32 * HP);     chk("lit_sp_lr_hi", lrclk, 1);
    get_word(8, 1'b1, wd); chk("lit_sp_right", wd, 24'h123456);

    // Backpressure: A then B
    sample_left = 24'h800001;
    sample_right = 24'h7FFFFF;
    sample_valid = 1'b1;
    wait_acc();
    sample_left = 24'h5A5A5A;
    sample_right = 24'hC3C3C3;
    wait_t(519); chk("lit_bp_ready519", sample_ready, 0);
    wait_t(520);
    chk("lit_bp_ready520", sample_ready, 1);
    chk("lit_bp_ur520", underrun, 0);
    wait_t(521); chk("lit_bp_ready521", sample_ready, 0);
    sample_valid = 1'b0;
    get_word(520, 1'b0, wd); chk("lit_bp_al", wd, 24'h800001);
    get_word(520, 1'b1, wd); chk("lit_bp_ar", wd, 24'h7FFFFF);
    wait_t(1032); chk("lit_bp_ur1032", underrun, 0);
    get_word(1032, 1'b0, wd); chk("lit_bp_bl", wd, 24'h5A5A5A);
    get_word(1032, 1'b1, wd); chk("lit_bp_br", wd, 24'hC3C3C3);

    // Accept on the frame-start edge with the hold empty
    wait_t(1543);
    sample_left = 24'h00F00F;
    sample_right = 24'hFFFFFF;
    sample_valid = 1'b1;
    wait_t(1544);
    sample_valid = 1'b0;
    chk("lit_sim_ur", underrun, 1);
    chk("lit_sim_ready", sample_ready, 0);
    get_word(1544, 1'b0, wd); chk("lit_sim_silent", wd, 0);
    wait_t(2056); chk("lit_sim_ur2", underrun, 0);
    get_word(2056, 1'b0, wd); chk("lit_sim_l", wd, 24'h00F00F);
    get_word(2056, 1'b1, wd); chk("lit_sim_r", wd, 24'hFFFFFF);

    // Reset mid-frame with a pair held
    sample_left = 24'h111111;
    sample_right = 24'h222222;
    sample_valid = 1'b1;
    wait_acc();
    sample_left = 24'h333333;
    sample_right = 24'h444444;
    wait_t(2569); chk("lit_mr_held", sample_ready, 0);
    sample_valid = 1'b0;
    wait_t(2568 + 40 * HP);
    do_reset();
    wait_t(1); chk("lit_mr_ready", sample_ready, 1);
    wait_t(8); chk("lit_mr_ur", underrun, 1);
    get_word(8, 1'b0, wd); chk("lit_mr_l", wd, 0);
    get_word(8, 1'b1, wd); chk("lit_mr_r", wd, 0);

    // Randomized traffic, inputs changing every cycle
    for (int i = 0; i < 6 * FR; i++) begin
      @(negedge clk);
      sample_valid = ($urandom_range(0, 3) == 0);
      sample_left = W'($urandom);
      sample_right = W'($urandom);
    end
    sample_valid = 1'b0;
    repeat (FR + 16) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/i2s_frame_tx.md
# i2s_frame_tx

Serialises stereo PCM sample pairs onto a standard Philips I2S link: bit clock, word-select (LR) clock and serial data, all derived from the single system clock. It sits directly downstream of the Raspberry Pi serial receiver. It accepts one left/right sample pair per frame through a valid/ready handshake into a one-deep holding register, then shifts the pair out MSB-first with the I2S one-bit delay. Missing data is replaced by silence and flagged as an underrun.

## Interface
- `WIDTH`, 24, sample width in bits; must satisfy 1 ≤ WIDTH ≤ SLOT_BITS-1.
- `SLOT_BITS`, 32, bit-clock periods per channel slot.
- `BCLK_DIV`, 4, clk cycles per bclk half-period; must be ≥ 1.

Ports:
- `clk` in 1: system clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `sample_left` in WIDTH: left sample, two's complement.
- `sample_right` in WIDTH: right sample, two's complement.
- `sample_valid` in 1: pair on inputs is valid.
- `sample_ready` out 1: holding register empty; a pair is accepted on a clk edge where valid && ready.
- `bclk` out 1: I2S bit clock.
- `lrclk` out 1: word select; 0 = left slot, 1 = right slot.
- `sdata` out 1: I2S serial data.
- `underrun` out 1: one-cycle pulse when a frame starts with the holding register empty.

## Operation
- **Divider.** `div_cnt` counts 0..BCLK_DIV-1. When it reaches BCLK_DIV-1 it wraps to 0 and `bclk` toggles.
- **Falling event.** A toggle from 1→0 is a "falling event"; all slot logic advances only on falling events.
- **Bit counter.** `bit_cnt` counts 0..2*SLOT_BITS-1 and increments on each falling event, wrapping to 0.
- **Frame start.** The falling event on which `bit_cnt` wraps to 0 is the frame start.
- **LR clock.** `lrclk` is registered and updates on falling events: 1 iff the new `bit_cnt` ≥ SLOT_BITS.
- **Slot position.** p = bit_cnt mod SLOT_BITS.
  - At p in 1..WIDTH, `sdata` carries bit WIDTH-p of the current channel's sample (MSB at p=1).
  - At p=0 and p > WIDTH, `sdata` is 0.
  - `sdata` updates only on falling events.
- **Holding register.** `hold_full` flag plus `hold_l`/`hold_r`.
  - `sample_ready` = !hold_full (registered-equivalent; it is 0 while `rst` is high).
  - Accept on valid && ready: capture both samples and set `hold_full`.
- **Frame load.** At frame start:
  - If `hold_full`: copy the holding register to the shift registers `sh_l`/`sh_r` and clear `hold_full`.
  - Otherwise: load zeros into `sh_l`/`sh_r` and pulse `underrun` for exactly one clk cycle.
- **Simultaneous accept and frame start with empty hold.** The frame loads zeros and flags underrun. The accepted pair lands in the holding register for the next frame. Data is never lost or duplicated.
- **Input stability.** Inputs are sampled only at the accept edge, so later changes on `sample_*` have no effect.

## Timing
- **Reset values** (held while `rst` = 1, effective at the next clk edge):
  - `bclk` = 0, `div_cnt` = 0, `bit_cnt` = 2*SLOT_BITS-1, `lrclk` = 1, `sdata` = 0, `underrun` = 0, `hold_full` = 0, `sh_l` = `sh_r` = 0.
  - `sample_ready` = 0 during reset and 1 from the first cycle after release.
- **Edges after reset release** (counting clk edges from the first edge with `rst` = 0 as edge 1):
  - `bclk` rises at edge BCLK_DIV.
  - `bclk` falls at edge 2*BCLK_DIV; this is the first frame start.
- **Frame timing.**
  - bclk period = 2*BCLK_DIV clk cycles.
  - Frame = 4*SLOT_BITS*BCLK_DIV clk cycles (512 at defaults).
  - `lrclk` falls at frame start; the left MSB appears one bclk period later, i.e. the I2S one-bit delay.
- **Handshake.**
  - `sample_ready` falls the cycle after an accept.
  - It rises the cycle after the frame start that consumed the pair.
  - Sustained throughput is one pair per frame.
- **Mid-operation reset.** Reset during a frame aborts it immediately and discards any held pair. The next frame start follows the same 2*BCLK_DIV schedule after release.

## Test plan
- **Reset values.** Hold `rst` 3 cycles, then release → check all reset values. Check `bclk` rises at edge 4 and falls at edge 8, where `lrclk` goes 0 and `underrun` pulses once.
- **Single pair.** Accept L=0xABCDEF, R=0x123456 on cycle 1 after release → first frame carries no underrun.
  - sdata bits at p=1..24 of the left slot read 0xABCDEF MSB-first.
  - Right slot reads 0x123456.
  - p=0 and p=25..31 are 0.
  - `lrclk` rises at bit_cnt 32.
- **Starvation.** Keep `sample_valid` = 0 for 3 frames → `sdata` constantly 0 and exactly one `underrun` pulse per frame start, 512 cycles apart.
- **Backpressure.** Hold valid high with pair A then pair B.
  - A is accepted; `ready` stays 0 until the cycle after the next frame start.
  - B is accepted then.
  - A then B are transmitted in consecutive frames, with no underrun between them.
- **Simultaneous accept at frame start.** Assert valid with hold empty exactly on the frame-start edge → that frame is silent with `underrun` = 1, and the following frame transmits the pair.
- **Reset mid-frame.** Assert `rst` mid-frame at bit_cnt 40 with a held pair → outputs return to reset values. After release, the first frame carries zeros plus `underrun`; the held pair is not transmitted.
